cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 140 ++++++++++++++
 tb/tb_cache_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares a single L2 port between an I-cache (read-only) and a
// D-cache (read or writeback). One L2 transaction at a time; ties between the
// two requesters are broken round-robin using the last granted requester.
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset_n,

  // I-cache side
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  // D-cache side
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  // L2 side
  output logic [ADDR_W-1:0] l2_addr,
  output logic              l2_read,
  output logic              l2_write,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  // 1 = D-cache received the most recent grant, 0 = I-cache did
  logic              last_grant_d_reg, last_grant_d_next;
  // Captured transaction: the L2 port is driven only from these while serving
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LINE_W-1:0] wdata_reg, wdata_next;
  logic              write_reg, write_next;

  logic              i_req;
  logic              d_req;
  logic              grant_i;
  logic              grant_d;
  logic              busy;

  // Arbitration: a lone requester always wins; on a tie the requester that
  // was not granted last time wins, which bounds waiting to one transaction.
  always_comb begin
    i_req   = i_read;
    d_req   = d_read | d_write;
    grant_i = i_req & (~d_req | last_grant_d_reg);
    grant_d = d_req & ~grant_i;
  end

  // State and capture registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      last_grant_d_reg <= 1'b1;
      addr_reg         <= '0;
      wdata_reg        <= '0;
      write_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      last_grant_d_reg <= last_grant_d_next;
      addr_reg         <= addr_next;
      wdata_reg        <= wdata_next;
      write_reg        <= write_next;
    end
  end

  // Next-state logic: grant and capture in IDLE, return to IDLE on l2_resp.
  always_comb begin
    state_next        = state_reg;
    last_grant_d_next = last_grant_d_reg;
    addr_next         = addr_reg;
    wdata_next        = wdata_reg;
    write_next        = write_reg;

    case (state_reg)
      IDLE: begin
        // l2_resp is deliberately not looked at here: a stray pulse is ignored
        if (grant_i) begin
          state_next        = SERVE_I;
          last_grant_d_next = 1'b0;
          addr_next         = i_addr;
          wdata_next        = '0;
          write_next        = 1'b0;
        end else if (grant_d) begin
          state_next        = SERVE_D;
          last_grant_d_next = 1'b1;
          addr_next         = d_addr;
          // A simultaneous read+write from the D-cache is treated as a write
          wdata_next        = d_write ? d_wdata : '0;
          write_next        = d_write;
        end
      end

      SERVE_I: begin
        if (l2_resp) begin
          state_next = IDLE;
        end
      end

      SERVE_D: begin
        if (l2_resp) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode: strobes and address come from the captured registers only,
  // so requester inputs can change freely once a transaction is granted.
  always_comb begin
    busy     = (state_reg == SERVE_I) || (state_reg == SERVE_D);
    l2_addr  = addr_reg;
    l2_wdata = wdata_reg;
    l2_read  = busy & ~write_reg;
    l2_write = busy & write_reg;
    i_resp   = (state_reg == SERVE_I) & l2_resp;
    d_resp   = (state_reg == SERVE_D) & l2_resp;
    // Read data passes straight through; qualified by the matching resp
    i_rdata  = l2_rdata;
    d_rdata  = l2_rdata;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: table of request scenarios applied in a loop, with an L2
// responder that pops expected transactions from a scoreboard queue, plus
// hand-written sequences for spurious l2_resp and mid-transaction reset.
module tb_cache_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] i_addr;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic [ADDR_W-1:0] d_addr;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic [ADDR_W-1:0] l2_addr;
  logic              l2_read;
  logic              l2_write;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_addr(l2_addr), .l2_read(l2_read), .l2_write(l2_write),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int txn_count = 0;

  typedef struct {
    bit                is_d;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    bit                ir;
    bit                dr;
    bit                dw;
    logic [ADDR_W-1:0] ia;
    logic [ADDR_W-1:0] da;
    logic [LINE_W-1:0] wd;
    logic [LINE_W-1:0] rd;
    int                lat;
    bit                mutate;
    bit                drop;
    bit                first_d;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t exp_i(input logic [ADDR_W-1:0] a);
    exp_t e;
    e.is_d = 1'b0; e.wr = 1'b0; e.addr = a; e.wdata = '0;
    return e;
  endfunction

  function automatic exp_t exp_d(input bit w, input logic [ADDR_W-1:0] a,
                                 input logic [LINE_W-1:0] wd);
    exp_t e;
    e.is_d = 1'b1; e.wr = w; e.addr = a; e.wdata = wd;
    return e;
  endfunction

  // Acts as L2 for one transaction. Entered #1 after a rising edge; returns
  // #1 after the edge that takes the arbiter back to IDLE.
  task automatic serve_one(input int lat, input bit mutate, input bit drop,
                           input logic [LINE_W-1:0] rdata);
    int n;
    exp_t e;
    n = 0;
    while (!(l2_read || l2_write) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(l2_read || l2_write)) begin
      check("grant_timeout", 0, 1);
      return;
    end
    check("grant_latency", n, 1);
    if (sb.size() == 0) begin
      check("sb_underflow", 0, 1);
      return;
    end
    e = sb.pop_front();
    check("l2_addr", l2_addr, e.addr);
    check("l2_strobes", {l2_read, l2_write}, {!e.wr, e.wr});
    if (e.wr) check("l2_wdata", l2_wdata, e.wdata);
    if (mutate) begin
      i_addr  = $urandom;
      d_addr  = $urandom;
      d_wdata = {8{$urandom}};
    end
    if (drop) begin
      if (e.is_d) begin d_read = 1'b0; d_write = 1'b0; end
      else i_read = 1'b0;
    end
    for (int k = 0; k < lat; k++) begin
      @(posedge clk); #1;
      check("hold_addr", l2_addr, e.addr);
      check("hold_strobes", {l2_read, l2_write}, {!e.wr, e.wr});
      if (e.wr) check("hold_wdata", l2_wdata, e.wdata);
      check("early_resp", {i_resp, d_resp}, 0);
    end
    l2_rdata = rdata;
    l2_resp  = 1'b1;
    #1;
    check("i_resp", i_resp, !e.is_d);
    check("d_resp", d_resp, e.is_d);
    if (e.is_d) check("d_rdata", d_rdata, rdata);
    else        check("i_rdata", i_rdata, rdata);
    @(posedge clk); #1;
    l2_resp  = 1'b0;
    l2_rdata = '0;
    if (e.is_d) begin d_read = 1'b0; d_write = 1'b0; end
    else i_read = 1'b0;
    check("idle_strobes", {l2_read, l2_write}, 0);
    check("resp_cleared", {i_resp, d_resp}, 0);
    txn_count++;
    $display("txn %0d: %s %s addr=%08h", txn_count, e.is_d ? "D" : "I",
             e.wr ? "write" : "read", e.addr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // ir dr dw  ia            da            wd                   rd                    lat mut drop first_d
    vecs[0]  = '{1, 0, 1, 32'h0000_0100, 32'h0000_0200, {8{32'h1111_2222}}, {8{32'h0BAD_F00D}}, 1, 0, 0, 0};
    vecs[1]  = '{1, 1, 0, 32'h0000_0104, 32'h0000_0208, '0,                 {8{32'h1234_5678}}, 2, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 32'h0000_1000, 32'h0,         '0,                 {32{8'hA5}},        3, 0, 0, 0};
    vecs[3]  = '{1, 0, 0, 32'h0000_2000, 32'h0,         '0,                 {8{32'hCAFE_0001}}, 0, 0, 0, 0};
    vecs[4]  = '{0, 1, 1, 32'h0,         32'h0000_0300, {8{32'h3333_4444}}, {8{32'h5555_6666}}, 2, 0, 0, 0};
    vecs[5]  = '{0, 1, 0, 32'h0,         32'h0000_0400, '0,                 {8{32'h7777_8888}}, 1, 0, 0, 0};
    vecs[6]  = '{1, 0, 1, 32'h0000_0500, 32'h0000_0600, {8{32'h9999_AAAA}}, {8{32'hBBBB_CCCC}}, 1, 0, 0, 0};
    vecs[7]  = '{0, 0, 1, 32'h0,         32'h0000_0700, {8{32'hDEAD_BEEF}}, {8{32'h0F0F_F0F0}}, 3, 1, 0, 0};
    vecs[8]  = '{1, 0, 0, 32'h0000_0800, 32'h0,         '0,                 {8{32'h1357_9BDF}}, 2, 0, 1, 0};
    vecs[9]  = '{0, 0, 1, 32'h0,         32'h0000_0900, {8{32'h2468_ACE0}}, {8{32'hFEDC_BA98}}, 2, 0, 1, 0};
    vecs[10] = '{1, 0, 0, 32'h0000_0A00, 32'h0,         '0,                 {8{32'h0A0A_0A0A}}, 0, 0, 0, 0};
    vecs[11] = '{1, 1, 0, 32'h0000_0B00, 32'h0000_0C00, '0,                 {8{32'h0C0C_0C0C}}, 1, 0, 0, 1};

    reset_n  = 1'b0;
    i_addr   = '0; i_read = 1'b0;
    d_addr   = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    l2_rdata = '0; l2_resp = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_strobes", {l2_read, l2_write}, 0);
    check("rst_resp", {i_resp, d_resp}, 0);
    check("rst_l2_addr", l2_addr, 0);
    check("rst_l2_wdata", l2_wdata, 0);
    reset_n = 1'b1;

    for (int r = 0; r < NVEC; r++) begin
      v = vecs[r];
      i_read = v.ir; d_read = v.dr; d_write = v.dw;
      i_addr = v.ia; d_addr = v.da; d_wdata = v.wd;
      if (v.ir && (v.dr || v.dw)) begin
        if (v.first_d) begin
          sb.push_back(exp_d(v.dw, v.da, v.wd));
          sb.push_back(exp_i(v.ia));
        end else begin
          sb.push_back(exp_i(v.ia));
          sb.push_back(exp_d(v.dw, v.da, v.wd));
        end
        serve_one(v.lat, 1'b0, 1'b0, v.rd);
        serve_one(v.lat, 1'b0, 1'b0, ~v.rd);
      end else if (v.ir) begin
        sb.push_back(exp_i(v.ia));
        serve_one(v.lat, v.mutate, v.drop, v.rd);
      end else begin
        sb.push_back(exp_d(v.dw, v.da, v.wd));
        serve_one(v.lat, v.mutate, v.drop, v.rd);
      end
    end

    // Spurious l2_resp while IDLE must be ignored
    l2_rdata = {8{32'h5A5A_5A5A}};
    l2_resp  = 1'b1;
    #1;
    check("spurious_resp", {i_resp, d_resp}, 0);
    @(posedge clk); #1;
    l2_resp = 1'b0;
    check("spurious_idle", {l2_read, l2_write}, 0);
    i_read = 1'b1; i_addr = 32'h0000_0D00;
    sb.push_back(exp_i(32'h0000_0D00));
    serve_one(1, 1'b0, 1'b0, {8{32'h6789_ABCD}});

    // Reset in the middle of a D writeback
    d_write = 1'b1; d_addr = 32'h0000_0E00; d_wdata = {8{32'hE0E0_E0E0}};
    @(posedge clk); #1;
    check("pre_rst_write", l2_write, 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_strobes", {l2_read, l2_write}, 0);
    check("async_rst_addr", l2_addr, 0);
    check("async_rst_wdata", l2_wdata, 0);
    l2_resp = 1'b1;
    #1;
    check("rst_no_d_resp", {i_resp, d_resp}, 0);
    l2_resp = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    sb.push_back(exp_d(1'b1, 32'h0000_0E00, {8{32'hE0E0_E0E0}}));
    serve_one(1, 1'b0, 1'b0, {8{32'h1F1F_1F1F}});

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
